// File: rtl/rr_event_encoder_pkg.sv
// Shared constants and helpers for the round-robin event encoder and future arbiters.
package rr_event_encoder_pkg;

    localparam int unsigned MAX_N = 32;
    localparam int unsigned MAX_W = 5;

    // Ceiling log2 for deriving code widths from line counts.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    localparam int unsigned N_DEF = 8;
    localparam int unsigned W_DEF = clog2(N_DEF);

    // Rotate the low n bits of v right by sh: result bit i = v[(i + sh) mod n].
    function automatic logic [MAX_N-1:0] rotate_mask(input logic [MAX_N-1:0] v,
                                                     input int unsigned sh,
                                                     input int unsigned n);
        logic [MAX_N-1:0] r;
        int unsigned      j;
        r = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                j = (i + sh) % n;
                r[i[MAX_W-1:0]] = v[j[MAX_W-1:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_event_encoder_pick.sv
// Combinational round-robin pick: first set bit of vec searching last+1 upward, wrapping.
module rr_pick
    import rr_event_encoder_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] last,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0]     start;
    logic [W-1:0]     k;
    logic [MAX_N-1:0] rot;

    // Rotate so last+1 lands at bit 0, fixed-priority encode, then un-rotate by adding back.
    always_comb begin
        start = last + 1'b1;
        rot   = rotate_mask(MAX_N'(vec), 32'(start), N);
        found = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rot[i[MAX_W-1:0]]) begin
                found = 1'b1;
                k     = W'(i);
            end
        end
        idx = start + k;
    end

endmodule

// File: rtl/rr_event_encoder.sv
// Sticky request capture with round-robin binary encoding behind a valid/ready handshake.
module rr_event_encoder
    import rr_event_encoder_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] code,
    output logic [N-1:0] pending,
    output logic         busy
);

    logic [N-1:0] pending_q, pending_d;
    logic         valid_q, valid_d;
    logic [W-1:0] code_q, code_d;
    logic [W-1:0] last_q, last_d;

    logic         accept;
    logic [N-1:0] clr;
    logic [N-1:0] sel;
    logic [W-1:0] ptr;
    logic         found;
    logic [W-1:0] pick_idx;

    // The just-accepted code acts as the search pointer in the same cycle it is retired.
    always_comb begin
        accept = valid_q & ready;
        clr    = accept ? (N'(1) << code_q) : '0;
        sel    = pending_q & ~clr;
        ptr    = accept ? code_q : last_q;
    end

    rr_pick #(.N(N), .W(W)) u_pick (
        .vec   (sel),
        .last  (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    // Next-state: capture/clear of pending (set wins), offer when the slot frees, pointer on accept.
    always_comb begin
        pending_d = (pending_q & ~clr) | (enable ? req : '0);
        valid_d   = valid_q;
        code_d    = code_q;
        last_d    = accept ? code_q : last_q;
        if (!valid_q || accept) begin
            valid_d = found;
            if (found) begin
                code_d = pick_idx;
            end
        end
    end

    // State registers; reset pointer to N-1 so the first search starts at index 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            last_q    <= '1;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            last_q    <= last_d;
        end
    end

    // Output drive.
    always_comb begin
        valid   = valid_q;
        code    = code_q;
        pending = pending_q;
        busy    = valid_q | (|pending_q);
    end

endmodule

// File: tb/tb_rr_event_encoder.sv
// Self-checking bench for rr_event_encoder: vector table, directed corner cases, random vs model.
module tb_rr_event_encoder;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [N-1:0] req;
    logic         ready;
    logic         valid;
    logic [2:0]   code;
    logic [N-1:0] pending;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_event_encoder #(.N(8), .W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .req     (req),
        .ready   (ready),
        .valid   (valid),
        .code    (code),
        .pending (pending),
        .busy    (busy)
    );

    typedef struct {
        bit       rst;
        bit [7:0] rq;
        bit       en;
        bit       rdy;
        bit       ev;
        bit [2:0] ec;
        bit [7:0] ep;
    } vec_t;

    vec_t tv[11];

    // Behavioural model: pending as an array of flags, pointer/code as plain integers.
    bit m_p[N];
    bit m_v;
    int m_code;
    int m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_p[i] = 1'b0;
        m_v    = 1'b0;
        m_code = 0;
        m_last = N - 1;
    endtask

    task automatic model_step(input logic [7:0] r, input bit en, input bit rdy);
        bit acc;
        int from;
        int old_code;
        bit base[N];
        bit hit;
        int pick;
        acc      = m_v && rdy;
        old_code = m_code;
        from     = acc ? old_code : m_last;
        for (int i = 0; i < N; i++) base[i] = m_p[i];
        if (acc) base[old_code] = 1'b0;
        hit  = 1'b0;
        pick = 0;
        if (!m_v || acc) begin
            for (int s = 1; s <= N; s++) begin
                int j;
                j = (from + s) % N;
                if (!hit && base[j]) begin
                    hit  = 1'b1;
                    pick = j;
                end
            end
            m_v = hit;
            if (hit) m_code = pick;
        end
        if (acc) m_last = old_code;
        for (int i = 0; i < N; i++) m_p[i] = base[i] | (en & r[i]);
    endtask

    function automatic logic [7:0] model_vec();
        logic [7:0] v;
        for (int i = 0; i < N; i++) v[i] = m_p[i];
        return v;
    endfunction

    task automatic do_reset();
        req     = '0;
        enable  = 1'b1;
        ready   = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic chk_out(input string tag, input bit ev, input int ec, input logic [7:0] ep);
        chk({tag, ".valid"},   32'(valid),   32'(ev));
        chk({tag, ".pending"}, 32'(pending), 32'(ep));
        chk({tag, ".busy"},    32'(busy),    32'(ev | (|ep)));
        if (ev) chk({tag, ".code"}, 32'(code), 32'(ec));
    endtask

    initial begin
        reset_n = 1'b1;
        enable  = 1'b1;
        req     = '0;
        ready   = 1'b0;
        model_reset();

        // Single event, then round-robin order 0,2,7 and wrap from pointer 7.
        tv[0]  = '{1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 3'd0, 8'h20};
        tv[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20};
        tv[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 8'h00};
        tv[3]  = '{1'b1, 8'h85, 1'b1, 1'b1, 1'b0, 3'd0, 8'h85};
        tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 8'h85};
        tv[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'h84};
        tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        tv[7]  = '{1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 3'd7, 8'h05};
        tv[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 8'h05};
        tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04};
        tv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 8'h00};

        // Reset held with all requests high, then released idle.
        reset_n = 1'b0;
        req     = 8'hFF;
        ready   = 1'b1;
        repeat (3) tick();
        chk("rst.valid",   32'(valid),   32'd0);
        chk("rst.pending", 32'(pending), 32'd0);
        chk("rst.busy",    32'(busy),    32'd0);
        chk("rst.code",    32'(code),    32'd0);
        @(negedge clk);
        req     = '0;
        reset_n = 1'b1;
        tick();
        tick();
        chk_out("idle", 1'b0, 0, 8'h00);
        chk("idle.code", 32'(code), 32'd0);

        // Vector table.
        for (int t = 0; t < 11; t++) begin
            if (tv[t].rst) do_reset();
            req    = tv[t].rq;
            enable = tv[t].en;
            ready  = tv[t].rdy;
            tick();
            chk_out($sformatf("vec%0d", t), tv[t].ev, int'(tv[t].ec), tv[t].ep);
            chk($sformatf("vec%0d.code_all", t), 32'(code), 32'(tv[t].ec));
        end

        // Backpressure: {3,6} pending, ready low for 5 cycles.
        do_reset();
        req   = 8'h48;
        ready = 1'b0;
        tick();
        chk_out("bp.load", 1'b0, 0, 8'h48);
        req = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_out($sformatf("bp.stall%0d", c), 1'b1, 3, 8'h48);
        end
        req   = 8'hFF;
        enable = 1'b0;
        tick();
        chk_out("bp.stall_req", 1'b1, 3, 8'h48);
        enable = 1'b1;
        req    = '0;
        ready  = 1'b1;
        tick();
        chk_out("bp.acc3", 1'b1, 6, 8'h40);
        tick();
        chk_out("bp.acc6", 1'b0, 0, 8'h00);

        // Set-wins collision on bit 4 while it is being accepted.
        do_reset();
        req   = 8'h50;
        ready = 1'b0;
        tick();
        req = '0;
        tick();
        chk_out("col.offer4", 1'b1, 4, 8'h50);
        req   = 8'h10;
        ready = 1'b1;
        tick();
        chk_out("col.setwins", 1'b1, 6, 8'h50);
        req = '0;
        tick();
        chk_out("col.reoffer4", 1'b1, 4, 8'h10);
        tick();
        chk_out("col.drained", 1'b0, 0, 8'h00);

        // enable=0 blocks capture but draining continues; async reset mid-drain.
        do_reset();
        req   = 8'h0F;
        ready = 1'b0;
        tick();
        chk_out("en.load", 1'b0, 0, 8'h0F);
        req    = 8'hFF;
        enable = 1'b0;
        ready  = 1'b1;
        tick();
        chk_out("en.offer0", 1'b1, 0, 8'h0F);
        tick();
        chk_out("en.acc0", 1'b1, 1, 8'h0E);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.valid",   32'(valid),   32'd0);
        chk("arst.pending", 32'(pending), 32'd0);
        chk("arst.busy",    32'(busy),    32'd0);
        @(negedge clk);
        req     = '0;
        enable  = 1'b1;
        ready   = 1'b0;
        reset_n = 1'b1;
        model_reset();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            req    = 8'($urandom) & 8'($urandom) & ((c % 200 < 20) ? 8'hFF : 8'($urandom));
            enable = ($urandom_range(0, 7) != 0);
            ready  = ($urandom_range(0, 2) != 0);
            model_step(req, enable, ready);
            tick();
            chk_out($sformatf("rnd%0d", c), m_v, m_code, model_vec());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_event_encoder.md
Name: rr_event_encoder

Overview:
- Sequential counterpart of the team's one-hot decoders: collects N request lines into sticky pending bits and encodes them into a binary index.
- Emits the index through a valid/ready handshake, one event at a time.
- Uses round-robin priority so no line starves.
- Sits between raw switch/button/event lines and consumers that want a binary code (display muxes, LED decoders, control FSMs).

Parameters:
- N, 8, number of request lines (power of 2, 2..32)
- W, 3, code width, must equal log2(N)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  capture enable; 0 = new req bits ignored, pending/output unaffected
- req  in  N  level request lines, one per source
- ready  in  1  consumer accepts code this cycle
- valid  out  1  code holds a pending event
- code  out  W  binary index of offered event
- pending  out  N  current sticky pending vector (registered)
- busy  out  1  valid | (|pending)

Behaviour:
- Reset (async, reset_n=0):
  - pending=0, valid=0, code=0, busy=0.
  - Round-robin pointer last=N-1, so the first search starts at index 0.
  - Reset mid-handshake drops all events; no partial state survives.
- Capture: each rising edge, pending <= (pending & ~clr) | (enable ? req : 0).
- Clear mask:
  - clr = one-hot(code) when valid & ready, else 0.
  - If the same bit is cleared and re-requested in one cycle, set wins and the bit stays pending.
- Output slot is free when valid=0 or (valid & ready).
- When the slot is free, the selector looks at sel = pending & ~clr (registered pending only; req in the same cycle is not visible):
  - Selection: the first set bit of sel searching last+1, last+2, ... wrapping modulo N.
  - sel != 0: valid<=1, code<=selected index.
  - sel == 0: valid<=0; code holds its old value (don't-care).
- When valid & ~ready: valid and code hold stable. No change while stalled, regardless of new requests.
- Pointer: last <= code on each accept (valid & ready). It is not updated on offer.
- Latency: req high at edge k → pending bit set at edge k → valid/code at edge k+1 if the slot is free (2 edges from req sample to valid).
- Throughput: with ready held 1, one code per cycle back-to-back.
- An offered bit stays in pending until accepted. It is never offered twice for a single pending episode.
- Boundaries:
  - All N bits pending: served in order last+1 … wrapping; every index is served within N accepts.
  - Pointer at N-1: the search wraps to 0.
  - enable=0 with pending bits: draining continues normally.
  - ready high while valid=0: no effect.

Decomposition:
- Shared package/header holds:
  - the N/W defaults;
  - a clog2-style constant function for deriving W;
  - the mask-rotate helper function, also usable by future arbiters.
- One natural sub-module: rr_pick, purely combinational. Inputs: vector and last pointer. Outputs: found flag and index (rotate, fixed-priority encode, un-rotate).
- The top level keeps pending, pointer and output registers plus the handshake.

Test Plan:
- Reset/idle: hold reset_n=0 with req=8'hFF → valid=0, pending=0, busy=0. Release with req=0 → outputs stay 0.
- Single event: 1-cycle pulse req=8'b0010_0000, ready=1 → pending[5]=1 one edge later, valid=1/code=5 the next edge, accepted. Then valid=0 and pending=0.
- Round-robin fairness: pulse req=8'b1000_0101 with ready=1 → codes 0,2,7 on consecutive cycles. A second pulse 8'h05 after the accept of 7 → codes 0,2 (wrap from pointer 7).
- Backpressure: pending = {3,6}, ready=0 for 5 cycles → valid=1, code=3 stable throughout. Raise ready → 3 then 6 accepted, each once.
- Set-wins collision: valid=1, code=4, ready=1, req[4]=1 in the same cycle → pending[4] stays 1 and code 4 is re-offered later, after the other pending bits in round-robin order.
- Enable and async reset: enable=0 with req=8'hFF → pending unchanged, drain continues. Assert reset_n low mid-drain between clock edges → valid and pending drop to 0 immediately, without waiting for clk.
